// File: rtl/hpu_alu_wb_if.sv
// Exec-result and writeback bus for the HPU ALU writeback stage.
// The slave modport is the writeback stage's view of the bus. The master
// modport is the view of whatever drives exec results and consumes writebacks.
interface hpu_alu_wb_if #(
  parameter int PHY_W = 7,
  parameter int ROB_W = 6
);

  logic             exec_vld_i;
  logic             exec_rdy_o;
  logic             exec_rdst_en_i;
  logic [PHY_W-1:0] exec_phy_rdst_i;
  logic [31:0]      exec_rdst_data_i;
  logic [ROB_W-1:0] exec_rob_id_i;
  logic             exec_is_ctrl_i;
  logic [31:0]      exec_next_pc_i;
  logic [31:0]      exec_pred_pc_i;

  logic             wb_vld_o;
  logic             wb_rdy_i;
  logic             wb_rdst_en_o;
  logic [PHY_W-1:0] wb_phy_rdst_o;
  logic [31:0]      wb_data_o;
  logic [ROB_W-1:0] wb_rob_id_o;

  modport slave (
    input  exec_vld_i, exec_rdst_en_i, exec_phy_rdst_i, exec_rdst_data_i,
           exec_rob_id_i, exec_is_ctrl_i, exec_next_pc_i, exec_pred_pc_i,
    output exec_rdy_o,
    output wb_vld_o, wb_rdst_en_o, wb_phy_rdst_o, wb_data_o, wb_rob_id_o,
    input  wb_rdy_i
  );

  modport master (
    output exec_vld_i, exec_rdst_en_i, exec_phy_rdst_i, exec_rdst_data_i,
           exec_rob_id_i, exec_is_ctrl_i, exec_next_pc_i, exec_pred_pc_i,
    input  exec_rdy_o,
    input  wb_vld_o, wb_rdst_en_o, wb_phy_rdst_o, wb_data_o, wb_rob_id_o,
    output wb_rdy_i
  );

endinterface

// File: rtl/hpu_alu_wb.sv
// HPU ALU writeback stage.
//
// Accepted ALU results are buffered in a small FIFO and written back to the ROB.
// A control instruction whose resolved next PC differs from its predicted PC
// triggers a one-cycle frontend redirect. After the redirect, the block swallows
// exec results until the pipeline reports that younger instructions have been
// purged.
//
// Optional feature: define HPU_ALU_WB_PERF_EN to add the perf_ctrl_cnt_o and
// perf_mispred_cnt_o performance counters.
module hpu_alu_wb #(
  parameter int PHY_W    = 7,
  parameter int ROB_W    = 6,
  parameter int WB_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  hpu_alu_wb_if.slave bus,
  output logic        redirect_vld_o,
  output logic [31:0] redirect_pc_o,
  input  logic        flush_done_i
`ifdef HPU_ALU_WB_PERF_EN
  ,
  output logic [31:0] perf_ctrl_cnt_o,
  output logic [31:0] perf_mispred_cnt_o
`endif
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int ENT_W = 1 + PHY_W + 32 + ROB_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ENT_W-1:0] fifoMem_q [WB_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic [31:0]      redirectPc_q;

  logic             fifoFull, fifoEmpty;
  logic             execRdy, accept, push, pop, mispredict, wbVld;
  logic [ENT_W-1:0] pushEntry, headEntry;

  assign fifoFull  = (count_q == (PTR_W+1)'(WB_DEPTH));
  assign fifoEmpty = (count_q == '0);

  // Ready is held low during reset, so a reset cycle can never accept anything.
  assign execRdy = !rst_i && (((state_q == RUN) && !fifoFull) || (state_q == DRAIN));
  assign bus.exec_rdy_o = execRdy;

  assign accept     = bus.exec_vld_i && execRdy;
  assign push       = accept && (state_q == RUN);
  assign mispredict = push && bus.exec_is_ctrl_i &&
                      (bus.exec_next_pc_i != bus.exec_pred_pc_i);

  assign wbVld        = !rst_i && !fifoEmpty;
  assign bus.wb_vld_o = wbVld;
  assign pop          = wbVld && bus.wb_rdy_i;

  assign pushEntry = {bus.exec_rdst_en_i, bus.exec_phy_rdst_i,
                      bus.exec_rdst_data_i, bus.exec_rob_id_i};
  assign headEntry = fifoMem_q[rdPtr_q];

  // The head is shown only while valid, so the payload reads as zero when idle or in reset.
  assign {bus.wb_rdst_en_o, bus.wb_phy_rdst_o, bus.wb_data_o, bus.wb_rob_id_o} =
    wbVld ? headEntry : '0;

  assign redirect_vld_o = !rst_i && (state_q == REDIR);
  assign redirect_pc_o  = rst_i ? 32'd0 : redirectPc_q;

  // Redirect FSM next-state logic. DRAIN waits for the pipeline to finish its flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mispredict) state_d = REDIR;
      REDIR:   state_d = DRAIN;
      DRAIN:   if (flush_done_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register. Reset returns to RUN, which abandons any redirect in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Capture the redirect target when the mispredicting result is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i)           redirectPc_q <= 32'd0;
    else if (mispredict) redirectPc_q <= bus.exec_next_pc_i;
  end

  // Writeback FIFO. Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) fifoMem_q[i] <= '0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= pushEntry;
        wrPtr_q            <= wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef HPU_ALU_WB_PERF_EN
  logic [31:0] ctrlCnt_q, mispredCnt_q;

  // Performance counters. Only results taken in RUN are counted; both wrap at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrlCnt_q    <= 32'd0;
      mispredCnt_q <= 32'd0;
    end else begin
      if (push && bus.exec_is_ctrl_i) ctrlCnt_q    <= ctrlCnt_q + 32'd1;
      if (mispredict)                 mispredCnt_q <= mispredCnt_q + 32'd1;
    end
  end

  assign perf_ctrl_cnt_o    = ctrlCnt_q;
  assign perf_mispred_cnt_o = mispredCnt_q;
`endif

endmodule

// File: tb/tb_hpu_alu_wb.sv
// Testbench for hpu_alu_wb.
// Expected writebacks are queued when stimulus is driven. The queue is popped
// and compared whenever the DUT completes a writeback handshake.
module tb_hpu_alu_wb;

  localparam int PHY_W = 7;
  localparam int ROB_W = 6;

  typedef struct packed {
    logic             rdstEn;
    logic [PHY_W-1:0] phy;
    logic [31:0]      data;
    logic [ROB_W-1:0] rob;
  } wbEntry_t;

  logic clk;
  logic rst;
  logic flushDone;
  logic redirectVld;
  logic [31:0] redirectPc;
`ifdef HPU_ALU_WB_PERF_EN
  logic [31:0] perfCtrlCnt, perfMispredCnt;
`endif

  int checkCount = 0;
  int passCount  = 0;
  wbEntry_t expQ[$];
  wbEntry_t gotExp;

  hpu_alu_wb_if #(.PHY_W(PHY_W), .ROB_W(ROB_W)) bus ();

  hpu_alu_wb #(.PHY_W(PHY_W), .ROB_W(ROB_W), .WB_DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus.slave),
    .redirect_vld_o (redirectVld),
    .redirect_pc_o  (redirectPc),
    .flush_done_i   (flushDone)
`ifdef HPU_ALU_WB_PERF_EN
    ,
    .perf_ctrl_cnt_o    (perfCtrlCnt),
    .perf_mispred_cnt_o (perfMispredCnt)
`endif
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    else
      passCount++;
  endtask

  // Drive one exec input; if the bench expects acceptance into the FIFO, queue the writeback
  task automatic applyStimulus(input logic vld, input logic ctrl, input logic rdstEn,
                               input logic [PHY_W-1:0] rdst, input logic [31:0] data,
                               input logic [ROB_W-1:0] rob, input logic [31:0] nextPc,
                               input logic [31:0] predPc, input logic expectWb);
    wbEntry_t e;
    bus.exec_vld_i       = vld;
    bus.exec_is_ctrl_i   = ctrl;
    bus.exec_rdst_en_i   = rdstEn;
    bus.exec_phy_rdst_i  = rdst;
    bus.exec_rdst_data_i = data;
    bus.exec_rob_id_i    = rob;
    bus.exec_next_pc_i   = nextPc;
    bus.exec_pred_pc_i   = predPc;
    if (expectWb) begin
      e.rdstEn = rdstEn;
      e.phy    = rdst;
      e.data   = data;
      e.rob    = rob;
      expQ.push_back(e);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 32'd0, '0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every completed writeback with the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.wb_vld_o && bus.wb_rdy_i) begin
      if (expQ.size() == 0) begin
        checkOutput("wb_unexpected", 64'(bus.wb_vld_o), 64'd0);
      end else begin
        gotExp = expQ.pop_front();
        checkOutput("wb_data",    64'(bus.wb_data_o),     64'(gotExp.data));
        checkOutput("wb_phy",     64'(bus.wb_phy_rdst_o), 64'(gotExp.phy));
        checkOutput("wb_rob",     64'(bus.wb_rob_id_o),   64'(gotExp.rob));
        checkOutput("wb_rdst_en", 64'(bus.wb_rdst_en_o),  64'(gotExp.rdstEn));
      end
    end
  end

  initial begin
    rst = 1'b1;
    flushDone = 1'b0;
    bus.wb_rdy_i = 1'b0;
    idle();
    nextCycle();

    // Reset: a valid exec during reset must be ignored and outputs held at zero
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd5, 32'hAAAA, 6'd3, 32'd0, 32'd0, 1'b0);
    bus.wb_rdy_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_wb_vld",    64'(bus.wb_vld_o),      64'd0);
    checkOutput("rst_exec_rdy",  64'(bus.exec_rdy_o),    64'd0);
    checkOutput("rst_redir_vld", 64'(redirectVld),       64'd0);
    checkOutput("rst_redir_pc",  64'(redirectPc),        64'd0);
    checkOutput("rst_wb_data",   64'(bus.wb_data_o),     64'd0);
    checkOutput("rst_wb_phy",    64'(bus.wb_phy_rdst_o), 64'd0);
    nextCycle();
    rst = 1'b0;

    // Basic result: one-cycle latency to writeback
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd5, 32'h1234, 6'd1, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t1_exec_rdy", 64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t1_wb_empty", 64'(bus.wb_vld_o),   64'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t1_wb_vld",    64'(bus.wb_vld_o), 64'd1);
    checkOutput("t1_no_redir",  64'(redirectVld),  64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_wb_drained", 64'(bus.wb_vld_o), 64'd0);
    nextCycle();

    // Backpressure: FIFO of two fills, third result is refused
    bus.wb_rdy_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd10, 32'h10, 6'd2, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t2_rdy0", 64'(bus.exec_rdy_o), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd11, 32'h11, 6'd3, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t2_rdy1", 64'(bus.exec_rdy_o), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd12, 32'h12, 6'd4, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("t2_rdy_full", 64'(bus.exec_rdy_o), 64'd0);
    checkOutput("t2_wb_vld",   64'(bus.wb_vld_o),   64'd1);
    nextCycle();
    idle();
    bus.wb_rdy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t2_pop_vld", 64'(bus.wb_vld_o), 64'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t2_empty", 64'(bus.wb_vld_o), 64'd0);
    nextCycle();

    // JAL mispredict: link written back, one-cycle redirect, then DRAIN discards
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd20, 32'h8C, 6'd7, 32'h100, 32'h104, 1'b1);
    @(negedge clk);
    checkOutput("t3_rdy",      64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t3_pre_redir", 64'(redirectVld),   64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd21, 32'hDEAD, 6'd8, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("t3_redir_rdy", 64'(bus.exec_rdy_o), 64'd0);
    checkOutput("t3_redir_vld", 64'(redirectVld),    64'd1);
    checkOutput("t3_redir_pc",  64'(redirectPc),     64'h100);
    checkOutput("t3_link_vld",  64'(bus.wb_vld_o),   64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd22, 32'h55, 6'd9, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("t3_drain_rdy0", 64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t3_redir_once", 64'(redirectVld),    64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd23, 32'h66, 6'd10, 32'h400, 32'h404, 1'b0);
    @(negedge clk);
    checkOutput("t3_drain_rdy1",  64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t3_drain_nowb",  64'(bus.wb_vld_o),   64'd0);
    nextCycle();
    idle();
    flushDone = 1'b1;
    @(negedge clk);
    checkOutput("t3_flush_rdy",     64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t3_drain_nodetect", 64'(redirectVld),   64'd0);
    nextCycle();
    flushDone = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd24, 32'h77, 6'd11, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t3_run_rdy",   64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t3_run_redir", 64'(redirectVld),    64'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t3_after_vld", 64'(bus.wb_vld_o), 64'd1);
    nextCycle();

    // Correctly predicted branch; flush_done in RUN is ignored
    flushDone = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd25, 32'h99, 6'd12, 32'h200, 32'h200, 1'b1);
    @(negedge clk);
    checkOutput("t4_rdy", 64'(bus.exec_rdy_o), 64'd1);
    nextCycle();
    flushDone = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("t4_no_redir", 64'(redirectVld),    64'd0);
    checkOutput("t4_run_rdy",  64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t4_wb_vld",   64'(bus.wb_vld_o),   64'd1);
`ifdef HPU_ALU_WB_PERF_EN
    checkOutput("t4_perf_ctrl",    64'(perfCtrlCnt),    64'd2);
    checkOutput("t4_perf_mispred", 64'(perfMispredCnt), 64'd1);
`endif
    nextCycle();

    // Reset during REDIR aborts the redirect and empties the FIFO
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd26, 32'hAB, 6'd13, 32'h300, 32'h304, 1'b1);
    nextCycle();
    rst = 1'b1;
    idle();
    @(negedge clk);
    checkOutput("t5_redir_vld", 64'(redirectVld),    64'd0);
    checkOutput("t5_redir_pc",  64'(redirectPc),     64'd0);
    checkOutput("t5_exec_rdy",  64'(bus.exec_rdy_o), 64'd0);
    checkOutput("t5_wb_vld",    64'(bus.wb_vld_o),   64'd0);
    nextCycle();
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("t5_run_rdy",  64'(bus.exec_rdy_o), 64'd1);
    checkOutput("t5_fifo_empty", 64'(bus.wb_vld_o), 64'd0);
    checkOutput("t5_no_pulse", 64'(redirectVld),    64'd0);
`ifdef HPU_ALU_WB_PERF_EN
    checkOutput("t5_perf_ctrl",    64'(perfCtrlCnt),    64'd0);
    checkOutput("t5_perf_mispred", 64'(perfMispredCnt), 64'd0);
`endif
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd27, 32'h4321, 6'd14, 32'd0, 32'd0, 1'b1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t5_post_vld", 64'(bus.wb_vld_o), 64'd1);
    nextCycle();
    @(negedge clk);

    checkOutput("sb_empty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hpu_alu_wb.md
HPU_ALU_WB -- requirements
Module: hpu_alu_wb

Interface
REQ-001 SHALL have parameter PHY_W, default 7, physical register index width.
REQ-002 SHALL have parameter ROB_W, default 6, ROB entry index width.
REQ-003 SHALL have parameter WB_DEPTH, default 2, writeback FIFO entries, power of two, at least 2.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 exec_vld_i  input  1  ALU exec result valid.
REQ-007 exec_rdy_o  output  1  block can accept an exec result.
REQ-008 exec_rdst_en_i  input  1  result writes a physical register.
REQ-009 exec_phy_rdst_i  input  PHY_W  destination physical register.
REQ-010 exec_rdst_data_i  input  32  ALU result data.
REQ-011 exec_rob_id_i  input  ROB_W  ROB tag.
REQ-012 exec_is_ctrl_i  input  1  instruction is BR, JAL or JALR.
REQ-013 exec_next_pc_i  input  32  resolved next PC from exec.
REQ-014 exec_pred_pc_i  input  32  frontend-predicted next PC.
REQ-015 wb_vld_o / wb_rdy_i  output / input  1 / 1  writeback handshake.
REQ-016 wb_rdst_en_o, wb_phy_rdst_o, wb_data_o, wb_rob_id_o  output  1 / PHY_W / 32 / ROB_W  writeback payload.
REQ-017 redirect_vld_o  output  1  one-cycle frontend redirect pulse.
REQ-018 redirect_pc_o  output  32  redirect target.
REQ-019 flush_done_i  input  1  pipeline reports younger instructions purged.

Function
REQ-020 An exec result SHALL be accepted when exec_vld_i and exec_rdy_o are both high in the same cycle.
REQ-021 Mispredict SHALL be defined as: accepted, exec_is_ctrl_i=1, and exec_next_pc_i != exec_pred_pc_i.
REQ-022 The FSM SHALL have three states: RUN, REDIR, DRAIN.
- RUN -> REDIR on a mispredict.
- REDIR -> DRAIN unconditionally after 1 cycle.
- DRAIN -> RUN in the cycle flush_done_i=1.
REQ-023 In RUN, exec_rdy_o SHALL equal "FIFO not full".
- Every accepted result, including a mispredicting one, SHALL be pushed into the FIFO.
REQ-024 In REDIR, exec_rdy_o SHALL be 0.
- redirect_vld_o SHALL be 1 for exactly that cycle.
- redirect_pc_o SHALL hold the mispredict's exec_next_pc_i, registered at acceptance.
REQ-025 In DRAIN, exec_rdy_o SHALL be 1.
- Accepted results SHALL be discarded: no FIFO push, no mispredict detection.
REQ-026 If flush_done_i=1 in RUN or REDIR, it SHALL be ignored.
REQ-027 The FIFO SHALL present its head combinationally on the wb_* outputs.
- wb_vld_o SHALL equal "FIFO not empty".
- A pop SHALL occur when wb_vld_o and wb_rdy_i are both high.
REQ-028 Latency SHALL be 1 cycle: a result accepted in cycle N SHALL appear on wb_* in cycle N+1 if the FIFO was empty.
REQ-029 Simultaneous push and pop when full SHALL NOT be allowed, because exec_rdy_o=0 when the FIFO is full.
REQ-030 Simultaneous push and pop when not full SHALL keep the occupancy count unchanged.
REQ-031 FIFO read and write pointers SHALL wrap modulo WB_DEPTH.
REQ-032 Results with exec_rdst_en_i=0 SHALL still be written back, with wb_rdst_en_o=0, so the ROB completes the entry.
REQ-033 The FIFO SHALL drain normally during REDIR and DRAIN.
REQ-034 redirect_vld_o SHALL be 0 in every state other than REDIR.

Reset
REQ-035 When rst_i=1 at a clock edge, the state SHALL go to RUN and the FIFO SHALL be emptied.
REQ-036 During reset, the outputs SHALL be:
- wb_vld_o=0 and exec_rdy_o=0.
- redirect_vld_o=0 and redirect_pc_o=0.
- wb payload outputs=0.
REQ-037 A reset asserted in REDIR or DRAIN SHALL abort the redirect without emitting any pulse.
REQ-038 Reset SHALL override all simultaneous handshakes.

Configuration
REQ-039 Macro HPU_ALU_WB_PERF_EN, when defined, SHALL add two outputs:
- perf_ctrl_cnt_o (32 bits): counts accepted control instructions in RUN.
- perf_mispred_cnt_o (32 bits): counts mispredicts.
REQ-040 With HPU_ALU_WB_PERF_EN defined, both counters SHALL reset to 0 and wrap at 2^32.
REQ-041 With HPU_ALU_WB_PERF_EN undefined, the ports and the counter logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Verification
REQ-042 Reset, then exec_vld_i=1 in RUN with a non-ctrl op, rdst=5, data=0x1234, wb_rdy_i=1 -> next cycle wb_vld_o=1, wb_phy_rdst_o=5, wb_data_o=0x1234; no redirect.
REQ-043 wb_rdy_i=0, three back-to-back valid results -> two accepted; exec_rdy_o=0 on the third cycle; after wb_rdy_i=1, pops come out in order.
REQ-044 JAL with next_pc=0x100, pred_pc=0x104, data=0x8C -> link 0x8C written back; next cycle redirect_vld_o=1, redirect_pc_o=0x100 for exactly 1 cycle; exec_rdy_o=0 in that cycle.
REQ-045 In DRAIN, two valid results accepted, then flush_done_i=1 -> neither is written back; state returns to RUN; the next result is written back.
REQ-046 Branch with next_pc==pred_pc=0x200 -> no redirect; with PERF_EN, perf_ctrl_cnt_o=1 and perf_mispred_cnt_o=0.
REQ-047 rst_i=1 in the REDIR cycle -> redirect_vld_o=0; FIFO empty; state RUN on the next cycle.
